bus_dig_display: RTL and testbench

Memory-mapped eight-digit seven-segment display controller, sitting downstream of the SoC bus bridge on the CPU data bus. It holds a 32-bit hex value and a control word written by the CPU, and time-multiplexes the eight common-anode digits onto `dig_en`/`DN_*`. It contains a refresh divider, a digit-scan counter and registered, glitch-free pad outputs. The bridge decodes the peripheral region and asserts `sel`. This block decodes only word offsets within its 16-byte window.

---
 rtl/bus_dig_display_pkg.sv | 20 ++
 rtl/bus_dig_display_seg7_hex_decode.sv | 31 +++
 rtl/bus_dig_display.sv | 138 +++++++++++++
 tb/tb_bus_dig_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_dig_display_pkg.sv
// Shared constants for the eight-digit seven-segment display peripheral:
// word offsets inside the 16-byte window, CTRL field positions and reset value.
package bus_dig_display_pkg;

    // Word offsets (Bus_addr[3:2]) inside the peripheral window
    localparam logic [1:0] DIG_OFF_DATA = 2'd0;
    localparam logic [1:0] DIG_OFF_CTRL = 2'd1;
    localparam logic [1:0] DIG_OFF_STAT = 2'd2;

    // CTRL layout: [7:0] blank mask, [15:8] decimal-point mask, [16] enable
    localparam int          DIG_CTRL_W   = 17;
    localparam int          DIG_CTRL_EN  = 16;
    localparam logic [31:0] DIG_CTRL_RST = 32'h0001_0000;

    // Only the implemented CTRL bits are kept; the rest read back as zero
    function automatic logic [DIG_CTRL_W-1:0] ctrl_from_word(input logic [31:0] word);
        return word[DIG_CTRL_W-1:0];
    endfunction

endpackage

// File: rtl/bus_dig_display_seg7_hex_decode.sv
// Hex digit to seven-segment pattern, active-low, bit order {G,F,E,D,C,B,A}.
module seg7_hex_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Standard hex font, lowercase b and d so they differ from 8 and 0
    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/bus_dig_display.sv
// Memory-mapped eight-digit common-anode display controller. Holds a 32-bit
// hex value plus a control word and scans one digit at a time onto
// registered, glitch-free active-low pads.
module bus_dig_display
    import bus_dig_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  dig_en,
    output logic        DN_A,
    output logic        DN_B,
    output logic        DN_C,
    output logic        DN_D,
    output logic        DN_E,
    output logic        DN_F,
    output logic        DN_G,
    output logic        DN_DP
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]           data_q;
    logic [DIG_CTRL_W-1:0] ctrl_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [DIV_W-1:0]      div_cnt_d;
    logic [2:0]            scan_idx_q;
    logic [2:0]            scan_idx_d;
    logic [7:0]            dig_en_q;
    logic [7:0]            dig_en_d;
    logic [6:0]            seg_q;
    logic [6:0]            seg_d;
    logic                  dp_q;
    logic                  dp_d;

    logic                  wr_data;
    logic                  wr_ctrl;
    logic                  digit_on;
    logic [3:0]            nibble;
    logic [6:0]            hex_seg;

    assign wr_data = sel && wen && (addr == DIG_OFF_DATA);
    assign wr_ctrl = sel && wen && (addr == DIG_OFF_CTRL);

    // Register file: whole-word writes, unmapped offsets ignore writes
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            data_q <= '0;
            ctrl_q <= ctrl_from_word(DIG_CTRL_RST);
        end else begin
            if (wr_data) data_q <= wdata;
            if (wr_ctrl) ctrl_q <= ctrl_from_word(wdata);
        end
    end

    // Combinational read mux; reads see the pre-write contents this cycle
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                DIG_OFF_DATA: rdata = data_q;
                DIG_OFF_CTRL: rdata = {{(32-DIG_CTRL_W){1'b0}}, ctrl_q};
                DIG_OFF_STAT: rdata = {29'd0, scan_idx_q};
                default:      rdata = '0;
            endcase
        end
    end

    // Refresh divider and scan index next state; the scan never stalls
    always_comb begin
        div_cnt_d  = div_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = '0;
            scan_idx_d = scan_idx_q + 3'd1;
        end
    end

    // Divider and scan counter state
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign digit_on = ctrl_q[DIG_CTRL_EN] && !ctrl_q[scan_idx_q];
    assign nibble   = data_q[{scan_idx_q, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .hex_i (nibble),
        .seg_o (hex_seg)
    );

    // One active-low enable per digit, low only for the lit scan slot
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dig_en
            assign dig_en_d[gi] = !(digit_on && (scan_idx_q == 3'(gi)));
        end
    endgenerate

    assign seg_d = digit_on ? hex_seg : 7'b1111111;
    assign dp_d  = digit_on ? !ctrl_q[8 + 32'(scan_idx_q)] : 1'b1;

    // Pad registers: everything leaves the block from a flop, dark in reset
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            dig_en_q <= 8'hFF;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign dig_en = dig_en_q;
    assign DN_A   = seg_q[0];
    assign DN_B   = seg_q[1];
    assign DN_C   = seg_q[2];
    assign DN_D   = seg_q[3];
    assign DN_E   = seg_q[4];
    assign DN_F   = seg_q[5];
    assign DN_G   = seg_q[6];
    assign DN_DP  = dp_q;

endmodule

// File: tb/tb_bus_dig_display.sv
// Directed bench for bus_dig_display with SCAN_DIV=4.
module tb_bus_dig_display;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [6:0] seg_tab [16];
    logic [6:0] segs;
    assign segs = {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A};

    bus_dig_display #(.SCAN_DIV(4)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .sel     (sel),
        .addr    (addr),
        .wen     (wen),
        .wdata   (wdata),
        .rdata   (rdata),
        .dig_en  (dig_en),
        .DN_A    (DN_A),
        .DN_B    (DN_B),
        .DN_C    (DN_C),
        .DN_D    (DN_D),
        .DN_E    (DN_E),
        .DN_F    (DN_F),
        .DN_G    (DN_G),
        .DN_DP   (DN_DP)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge cpu_clk);
        #1;
        cyc++;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wen = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; wen = 1'b0; addr = a;
        #1;
        chk(tag, rdata, exp);
        sel = 1'b0;
    endtask

    // Digit shown on the pads after edge cyc (cyc counted from reset release)
    function automatic int shown_digit();
        return ((cyc - 1) / 4) % 8;
    endfunction

    initial begin
        int d;
        bit found;
        logic [7:0] exp_en;
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        // Reset held
        tick(); tick();
        chk("rst_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        chk("rst_segs", {25'd0, segs}, 32'h0000_007F);
        chk("rst_dp", {31'd0, DN_DP}, 32'd1);
        bus_read("rst_ctrl", 2'd1, 32'h0001_0000);
        bus_read("rst_data", 2'd0, 32'h0000_0000);

        // Release: digit 0 showing '0' one cycle later
        cpu_rst = 1'b0;
        cyc = 0;
        tick();
        chk("rel_dig_en", {24'd0, dig_en}, 32'h0000_00FE);
        chk("rel_segs", {25'd0, segs}, {25'd0, 7'b1000000});
        chk("rel_dp", {31'd0, DN_DP}, 32'd1);

        // DATA = 0x87654321, observe a full frame plus the wrap
        bus_write(2'd0, 32'h8765_4321);
        for (int i = 0; i < 34; i++) begin
            tick();
            d = shown_digit();
            exp_en = ~(8'd1 << d);
            chk($sformatf("frame_en_d%0d", d), {24'd0, dig_en}, {24'd0, exp_en});
            chk($sformatf("frame_seg_d%0d", d), {25'd0, segs}, {25'd0, seg_tab[d + 1]});
            chk($sformatf("frame_dp_d%0d", d), {31'd0, DN_DP}, 32'd1);
        end

        // Blank digit 2, decimal point on digit 1
        bus_write(2'd1, 32'h0001_0204);
        for (int i = 0; i < 33; i++) begin
            tick();
            d = shown_digit();
            exp_en = (d == 2) ? 8'hFF : ~(8'd1 << d);
            chk($sformatf("ctl_en_d%0d", d), {24'd0, dig_en}, {24'd0, exp_en});
            chk($sformatf("ctl_seg_d%0d", d), {25'd0, segs},
                {25'd0, (d == 2) ? 7'b1111111 : seg_tab[d + 1]});
            chk($sformatf("ctl_dp_d%0d", d), {31'd0, DN_DP}, (d == 1) ? 32'd0 : 32'd1);
        end

        // Read-back and bus decode
        bus_read("rd_data", 2'd0, 32'h8765_4321);
        bus_read("rd_ctrl", 2'd1, 32'h0001_0204);
        bus_write(2'd1, 32'hFFFF_0204);
        bus_read("rd_ctrl_mask", 2'd1, 32'h0001_0204);
        bus_read("rd_0c", 2'd3, 32'h0000_0000);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read("rd_0c_after_wr", 2'd3, 32'h0000_0000);
        sel = 1'b0; addr = 2'd0; #1;
        chk("rd_nosel", rdata, 32'h0000_0000);
        sel = 1'b0; wen = 1'b1; addr = 2'd0; wdata = 32'h1234_5678;
        tick();
        wen = 1'b0;
        bus_read("wr_nosel_ignored", 2'd0, 32'h8765_4321);
        sel = 1'b1; wen = 1'b0; addr = 2'd0; wdata = 32'h1234_5678;
        tick();
        bus_read("wr_nowen_ignored", 2'd0, 32'h8765_4321);
        sel = 1'b1; wen = 1'b1; addr = 2'd0; wdata = 32'hDEAD_BEEF; #1;
        chk("rd_during_wr_old", rdata, 32'h8765_4321);
        tick();
        sel = 1'b0; wen = 1'b0;
        bus_read("rd_after_wr_new", 2'd0, 32'hDEAD_BEEF);
        bus_write(2'd0, 32'h8765_4321);

        // Display disabled: pads dark, scan index keeps moving
        bus_write(2'd1, 32'h0000_0000);
        tick();
        sel = 1'b1; addr = 2'd2;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("off_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
            chk("off_segs", {25'd0, segs}, 32'h0000_007F);
            chk("off_status", rdata, 32'((cyc / 4) % 8));
        end
        sel = 1'b0;

        // Reset while digit 5 is lit
        bus_write(2'd1, 32'h0001_0000);
        tick();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (shown_digit() == 5) found = 1'b1;
        end
        chk("reach_digit5", {31'd0, found}, 32'd1);
        chk("d5_dig_en", {24'd0, dig_en}, 32'h0000_00DF);
        chk("d5_segs", {25'd0, segs}, {25'd0, seg_tab[6]});
        #1;
        cpu_rst = 1'b1;
        #1;
        chk("async_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        chk("async_segs", {25'd0, segs}, 32'h0000_007F);
        chk("async_dp", {31'd0, DN_DP}, 32'd1);
        bus_read("async_data", 2'd0, 32'h0000_0000);
        bus_read("async_status", 2'd2, 32'h0000_0000);
        tick();
        cpu_rst = 1'b0;
        cyc = 0;
        tick();
        chk("rerel_dig_en", {24'd0, dig_en}, 32'h0000_00FE);
        chk("rerel_segs", {25'd0, segs}, {25'd0, 7'b1000000});
        for (int i = 0; i < 4; i++) tick();
        chk("rerel_next_dig", {24'd0, dig_en}, 32'h0000_00FD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
